// File: rtl/jtframe_rom_nslots.sv
// N-slot read-only SDRAM arbiter with a one-word cache per slot; one SDRAM read in flight.
// Grant one cycle after request (or on data_rdy); slot_ok the cycle after data_rdy; clients wait on slot_ok.
module jtframe_rom_nslots #(
   parameter int SLOTS  = 4,
   parameter int SDRAMW = 22,
   parameter int AW     = 20,
   parameter int RR     = 0,
   parameter logic [SLOTS*SDRAMW-1:0] OFFSETS = '0
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [SLOTS-1:0]      slot_cs,
   input  logic [SLOTS*AW-1:0]   slot_addr,
   output logic [SLOTS*16-1:0]   slot_dout,
   output logic [SLOTS-1:0]      slot_ok,
   output logic                  sdram_rd,
   output logic [SDRAMW-1:0]     sdram_addr,
   input  logic                  sdram_ack,
   input  logic                  data_rdy,
   input  logic [15:0]           data_read
);
   localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic [SLOTS-1:0]  valid_q, valid_d;
   logic [AW-1:0]     caddr_q [SLOTS];
   logic [AW-1:0]     caddr_d [SLOTS];
   logic [15:0]       cdata_q [SLOTS];
   logic [15:0]       cdata_d [SLOTS];
   logic [SLOTS-1:0]  sel_q, sel_d;
   logic              rd_q, rd_d;
   logic [SDRAMW-1:0] addr_q, addr_d;
   logic [AW-1:0]     paddr_q, paddr_d;
   logic [IW-1:0]     rr_q, rr_d;

   logic [SLOTS-1:0]  hit, req, active;
   logic [AW-1:0]     saddr [SLOTS];
   logic [SDRAMW-1:0] offs [SLOTS];
   logic              gnt_vld;
   logic [IW-1:0]     gnt_idx;
   int                base;

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      assign saddr[i]              = slot_addr[i*AW +: AW];
      assign offs[i]               = OFFSETS[i*SDRAMW +: SDRAMW];
      assign hit[i]                = valid_q[i] & (saddr[i] == caddr_q[i]);
      assign req[i]                = slot_cs[i] & ~hit[i];
      assign slot_ok[i]            = slot_cs[i] & hit[i];
      assign slot_dout[i*16 +: 16] = cdata_q[i];
   end

   // The slot being served is masked so it cannot re-request before its cache entry lands
   assign active     = req & ~sel_q;
   assign sdram_rd   = rd_q;
   assign sdram_addr = addr_q;

   function automatic logic [IW-1:0] wrap(input int v);
      return IW'(v % SLOTS);
   endfunction

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      base    = (RR != 0) ? int'(rr_q) + 1 : 0;
      for (int k = 0; k < SLOTS; k++) begin
         if (!gnt_vld && active[wrap(base + k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap(base + k);
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      caddr_d = caddr_q;
      cdata_d = cdata_q;
      sel_d   = sel_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      paddr_d = paddr_q;
      rr_d    = rr_q;
      if (sdram_ack) rd_d = 1'b0;
      if (data_rdy && sel_q != '0) begin
         for (int i = 0; i < SLOTS; i++) begin
            if (sel_q[i]) begin
               valid_d[i] = 1'b1;
               caddr_d[i] = paddr_q;
               cdata_d[i] = data_read;
            end
         end
      end
      // Flush after the fill so a coincident completion is left invalid
      if (flush) valid_d = '0;
      if (sel_q == '0 || data_rdy) begin
         sel_d = gnt_vld ? (SLOTS'(1) << gnt_idx) : '0;
         rd_d  = gnt_vld;
         if (gnt_vld) begin
            addr_d  = offs[gnt_idx] + SDRAMW'(saddr[gnt_idx]);
            paddr_d = saddr[gnt_idx];
            rr_d    = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         sel_q   <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         paddr_q <= '0;
         rr_q    <= IW'(SLOTS - 1);
         for (int i = 0; i < SLOTS; i++) begin
            caddr_q[i] <= '0;
            cdata_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         caddr_q <= caddr_d;
         cdata_q <= cdata_d;
         sel_q   <= sel_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         paddr_q <= paddr_d;
         rr_q    <= rr_d;
      end
   end
endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// Bench for jtframe_rom_nslots: SDRAM responder, transaction-level reference model and
// scoreboard of issued read addresses plus per-cycle slot_ok/slot_dout checks.
module tb_jtframe_rom_nslots;
   localparam int SLOTS = 4;
   localparam int AW    = 20;
   localparam int RR    = 1;
   localparam logic [SLOTS*22-1:0] OFFS = {22'h3FFFFF, 22'h000000, 22'h020000, 22'h001000};

   logic                clk = 1'b0;
   logic                rst_n;
   logic                flush;
   logic [SLOTS-1:0]    slot_cs;
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS*16-1:0] slot_dout;
   logic [SLOTS-1:0]    slot_ok;
   logic                sdram_rd;
   logic [21:0]         sdram_addr;
   logic                sdram_ack;
   logic                data_rdy;
   logic [15:0]         data_read;

   jtframe_rom_nslots #(.SLOTS(SLOTS), .SDRAMW(22), .AW(AW), .RR(RR), .OFFSETS(OFFS)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .slot_cs(slot_cs), .slot_addr(slot_addr),
      .slot_dout(slot_dout), .slot_ok(slot_ok), .sdram_rd(sdram_rd), .sdram_addr(sdram_addr),
      .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem(input logic [21:0] a);
      return a[15:0] ^ {a[21:16], a[21:12]} ^ 16'h5A3C;
   endfunction

   logic [21:0] toff [SLOTS];
   initial begin
      toff[0] = 22'h001000;
      toff[1] = 22'h020000;
      toff[2] = 22'h000000;
      toff[3] = 22'h3FFFFF;
   end

   // ---------------- reference model ----------------
   bit          mvalid [SLOTS];
   logic [AW-1:0] maddr [SLOTS];
   logic [15:0] mdata [SLOTS];
   int          msel, mptr, mg;
   logic [AW-1:0] mpaddr;
   logic [21:0] mexp;
   logic [SLOTS-1:0] mact;
   logic [21:0] exp_q [$];
   logic [21:0] issued [$];

   function automatic int pick(input logic [SLOTS-1:0] act, input int ptr);
      for (int k = 1; k <= SLOTS; k++) begin
         int j = (RR != 0) ? (ptr + k) % SLOTS : k - 1;
         if (act[j]) return j;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) begin
            mvalid[i] = 1'b0; maddr[i] = '0; mdata[i] = '0;
         end
         msel = -1;
         mptr = SLOTS - 1;
         exp_q.delete();
      end else begin
         for (int i = 0; i < SLOTS; i++)
            mact[i] = slot_cs[i] && !(mvalid[i] && maddr[i] == slot_addr[i*AW +: AW]) && (i != msel);
         if (msel < 0 || data_rdy) begin
            if (data_rdy && msel >= 0) begin
               mvalid[msel] = 1'b1; maddr[msel] = mpaddr; mdata[msel] = mem(mexp);
            end
            mg   = pick(mact, mptr);
            msel = mg;
            if (mg >= 0) begin
               mptr   = mg;
               mpaddr = slot_addr[mg*AW +: AW];
               mexp   = toff[mg] + 22'(mpaddr);
               exp_q.push_back(mexp);
            end
         end
         if (flush) for (int i = 0; i < SLOTS; i++) mvalid[i] = 1'b0;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   bit prev_rd;
   logic [SLOTS-1:0] eok;
   always @(negedge clk) begin
      if (!rst_n) prev_rd = 1'b0;
      else begin
         if (sdram_rd && !prev_rd) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL req_unexpected: got read 0x%0h expected none at %0t", sdram_addr, $time);
            end else check("req_addr", sdram_addr, exp_q.pop_front());
            issued.push_back(sdram_addr);
         end
         prev_rd = sdram_rd;
         for (int i = 0; i < SLOTS; i++)
            eok[i] = slot_cs[i] && mvalid[i] && maddr[i] == slot_addr[i*AW +: AW];
         check("slot_ok", slot_ok, eok);
         for (int i = 0; i < SLOTS; i++)
            if (eok[i]) check("slot_dout", slot_dout[i*16 +: 16], mdata[i]);
      end
   end

   // ---------------- SDRAM responder ----------------
   int  rstate = 0, rcnt = 0, flush_pct = 0;
   bit  stray = 0, flush_on_data = 0;
   logic [21:0] raddr;
   initial begin
      sdram_ack = 0; data_rdy = 0; data_read = 0; flush = 0;
      forever begin
         @(posedge clk); #1;
         sdram_ack = 0; data_rdy = 0; flush = 0;
         if (!rst_n) rstate = 0;
         else begin
            if (rstate == 0) begin
               if (stray) begin
                  data_rdy = 1; data_read = 16'hDEAD; stray = 0;
               end else if (sdram_rd) begin
                  raddr = sdram_addr; rcnt = $urandom_range(0, 2); rstate = 1;
               end
            end
            if (rstate == 1) begin
               if (rcnt == 0) begin
                  sdram_ack = 1; rstate = 2; rcnt = $urandom_range(0, 3);
               end else rcnt--;
            end else if (rstate == 2) begin
               if (rcnt == 0) begin
                  data_rdy = 1; data_read = mem(raddr); rstate = 0;
                  if (flush_on_data) begin flush = 1; flush_on_data = 0; end
               end else rcnt--;
            end
            if ($urandom_range(0, 99) < flush_pct) flush = 1;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ok(input int s, input string nm);
      int n = 0;
      while (!slot_ok[s] && n < 200) begin @(negedge clk); n++; end
      check(nm, 64'(slot_ok[s]), 64'd1);
   endtask

   task automatic wait_issued(input int cnt, input string nm);
      int n = 0;
      while (issued.size() < cnt && n < 200) begin @(negedge clk); n++; end
      check(nm, 64'(issued.size() >= cnt), 64'd1);
   endtask

   function automatic logic [63:0] iss(input int k);
      return (k < issued.size()) ? 64'(issued[k]) : 64'hFFFF_FFFF;
   endfunction

   function automatic logic [AW-1:0] a20(input int v);
      return AW'(v);
   endfunction

   // ---------------- stimulus ----------------
   int base, n0, to;
   initial begin
      rst_n = 0; slot_cs = '0; slot_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sdram_rd", 64'(sdram_rd), 64'd0);
      check("rst_sdram_addr", 64'(sdram_addr), 64'd0);
      check("rst_slot_ok", 64'(slot_ok), 64'd0);
      check("rst_slot_dout", 64'(slot_dout), 64'd0);
      #1 rst_n = 1;
      step(1);

      // single slot miss then hit
      slot_cs[0] = 1; slot_addr[0 +: AW] = a20('h10);
      wait_ok(0, "t1_ok_timeout");
      check("t1_addr", iss(0), 64'h001010);
      check("t1_dout", 64'(slot_dout[15:0]), 64'(mem(22'h001010)));
      n0 = issued.size();
      step(6);
      check("t1_hit_no_read", 64'(issued.size()), 64'(n0));
      slot_cs = '0;
      step(2);

      // round-robin order with re-request and offset wrap
      base = issued.size();
      slot_cs[3:1] = 3'b111;
      slot_addr[1*AW +: AW] = a20(5); slot_addr[2*AW +: AW] = a20(6); slot_addr[3*AW +: AW] = a20(2);
      wait_ok(1, "t2_ok1_timeout");
      @(posedge clk); #1;
      slot_addr[1*AW +: AW] = a20(9);
      wait_ok(3, "t2_ok3_timeout");
      wait_ok(1, "t2_ok1b_timeout");
      check("t2_order0", iss(base),     64'h020005);
      check("t2_order1", iss(base + 1), 64'h000006);
      check("t2_order2", iss(base + 2), 64'h000001);
      check("t2_order3", iss(base + 3), 64'h020009);
      slot_cs = '0;
      step(2);

      // address change while pending
      base = issued.size();
      slot_cs[2] = 1; slot_addr[2*AW +: AW] = a20('h20);
      wait_issued(base + 1, "t3_issue_timeout");
      @(posedge clk); #1;
      slot_addr[2*AW +: AW] = a20('h24);
      wait_ok(2, "t3_ok_timeout");
      check("t3_first",  iss(base),     64'h000020);
      check("t3_second", iss(base + 1), 64'h000024);
      slot_cs = '0;
      step(2);

      // flush coincident with completion
      base = issued.size();
      flush_on_data = 1;
      slot_cs[0] = 1; slot_addr[0 +: AW] = a20('h33);
      wait_ok(0, "t4_ok_timeout");
      check("t4_reads", 64'(issued.size() - base), 64'd2);
      check("t4_reissue", iss(base + 1), 64'h001033);
      slot_cs = '0;
      step(2);

      // reset mid-transfer, then stray data_rdy
      slot_cs[1] = 1; slot_addr[1*AW +: AW] = a20('h44);
      to = 0;
      while (!sdram_rd && to < 50) begin @(negedge clk); to++; end
      check("t5_rd_seen", 64'(sdram_rd), 64'd1);
      #1 rst_n = 0;
      #1;
      check("t5_rd_low", 64'(sdram_rd), 64'd0);
      check("t5_addr_zero", 64'(sdram_addr), 64'd0);
      check("t5_ok_zero", 64'(slot_ok), 64'd0);
      check("t5_dout_zero", 64'(slot_dout), 64'd0);
      slot_cs = '0;
      n0 = issued.size();
      @(posedge clk); #2 rst_n = 1;
      step(1);
      stray = 1;
      step(8);
      check("t5_no_ok", 64'(slot_ok), 64'd0);
      check("t5_no_read", 64'(issued.size()), 64'(n0));

      // randomized traffic
      flush_pct = 3;
      for (int c = 0; c < 2500; c++) begin
         @(posedge clk); #1;
         for (int i = 0; i < SLOTS; i++) begin
            if ($urandom_range(0, 99) < 6) slot_cs[i] = ~slot_cs[i];
            if ($urandom_range(0, 99) < 5) slot_addr[i*AW +: AW] = a20($urandom_range(0, 5));
         end
      end
      flush_pct = 0;
      slot_cs = '0;
      step(40);
      check("drain_expected_reads", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
